// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite initiator: one single-beat read or write per host command,
// with a watchdog that aborts a transaction when the slave stops responding.
module axi_lite_master_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [2:0]           state;
    logic                 aw_done;
    logic                 w_done;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 wd_active;
    logic                 wd_expired;
    logic [CNT_WIDTH-1:0] wd_cnt;

    assign cmd_ready    = (state == ST_IDLE);
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    assign aw_hs      = m_axi_awvalid & m_axi_awready;
    assign w_hs       = m_axi_wvalid & m_axi_wready;
    assign wd_active  = (state != ST_IDLE) && (state != ST_RSP);
    // Expires on the TIMEOUT_CYCLES-th active cycle so the response lands that many cycles after issue.
    assign wd_expired = (TIMEOUT_CYCLES != 0) && wd_active && (wd_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt <= '0;
        end else if (wd_active) begin
            wd_cnt <= wd_cnt + CNT_WIDTH'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
        end else if (wd_expired) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b10;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= ST_RSP;
        end else begin
            case (state)
                ST_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (cmd_valid) begin
                        m_axi_awaddr <= cmd_addr;
                        m_axi_araddr <= cmd_addr;
                        m_axi_wdata  <= cmd_wdata;
                        m_axi_wstrb  <= cmd_wstrb;
                        if (cmd_write) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= ST_WR_REQ;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end
                ST_RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Directed bench for axi_lite_master_ctrl: a table of transactions against a
// configurable-delay slave, plus reset and response-hold sequences.
module tb_axi_lite_master_ctrl;

    localparam int NEVER = 99;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    axi_lite_master_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awprot (m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        int          ar_dly;
        int          r_dly;
        logic [1:0]  s_resp;
        logic [31:0] s_rdata;
        int          rsp_hold;
        int          exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic        exp_to;
        logic [4:0]  exp_hs;   // {aw, w, b, ar, r} handshake counts
    } vec_t;

    vec_t vecs[11];
    vec_t final_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rresp   = 2'b00;
        m_axi_rdata   = '0;
    endtask

    function automatic logic [31:0] chan_bits();
        return {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready};
    endfunction

    task automatic run_txn(input vec_t v, input int idx);
        int  cyc = 1;
        bit  got = 1'b0;
        bit  payload_ok = 1'b1;
        int  aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        int  aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
        string tag;
        tag = $sformatf("v%0d", idx);

        check({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wstrb = v.strb;
        @(negedge clk_i);
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFF0;
        cmd_wdata = 32'h0;

        while (cyc <= 40) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (m_axi_awvalid && (!v.write || m_axi_awaddr !== v.addr)) payload_ok = 1'b0;
            if (m_axi_wvalid && (!v.write || m_axi_wdata !== v.wdata || m_axi_wstrb !== v.strb))
                payload_ok = 1'b0;
            if (m_axi_arvalid && (v.write || m_axi_araddr !== v.addr)) payload_ok = 1'b0;
            if (m_axi_awprot !== 3'b000 || m_axi_arprot !== 3'b000) payload_ok = 1'b0;

            m_axi_bresp = v.s_resp;
            if (v.write && aw_hs > 0 && w_hs > 0 && b_hs == 0) begin
                m_axi_bvalid = (b_cnt >= v.b_dly);
                b_cnt++;
            end else begin
                m_axi_bvalid = 1'b0;
            end
            if (m_axi_bvalid && m_axi_bready) b_hs++;

            m_axi_rresp = v.s_resp;
            m_axi_rdata = v.s_rdata;
            if (!v.write && ar_hs > 0 && r_hs == 0) begin
                m_axi_rvalid = (r_cnt >= v.r_dly);
                r_cnt++;
            end else begin
                m_axi_rvalid = 1'b0;
            end
            if (m_axi_rvalid && m_axi_rready) r_hs++;

            if (m_axi_awvalid) begin
                m_axi_awready = (aw_cnt >= v.aw_dly);
                aw_cnt++;
                if (m_axi_awready) aw_hs++;
            end else begin
                m_axi_awready = 1'b0;
            end
            if (m_axi_wvalid) begin
                m_axi_wready = (w_cnt >= v.w_dly);
                w_cnt++;
                if (m_axi_wready) w_hs++;
            end else begin
                m_axi_wready = 1'b0;
            end
            if (m_axi_arvalid) begin
                m_axi_arready = (ar_cnt >= v.ar_dly);
                ar_cnt++;
                if (m_axi_arready) ar_hs++;
            end else begin
                m_axi_arready = 1'b0;
            end

            @(negedge clk_i);
            cyc++;
        end
        slave_idle();

        check({tag, ".rsp_seen"}, 32'(got), 32'd1);
        if (!got) return;
        check({tag, ".latency"}, 32'(cyc), 32'(v.exp_lat));
        check({tag, ".resp"}, 32'(rsp_resp), 32'(v.exp_resp));
        check({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, ".timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
        check({tag, ".chan_idle"}, chan_bits(), 32'd0);
        check({tag, ".payload"}, 32'(payload_ok), 32'd1);
        check({tag, ".hs"}, {12'd0, 4'(aw_hs), 4'(w_hs), 4'(b_hs), 4'(ar_hs), 4'(r_hs)},
              {12'd0, 3'd0, v.exp_hs[4], 3'd0, v.exp_hs[3], 3'd0, v.exp_hs[2],
               3'd0, v.exp_hs[1], 3'd0, v.exp_hs[0]});

        for (int h = 0; h < v.rsp_hold; h++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 32'hFFFF_FFFC;
            @(negedge clk_i);
            check({tag, ".hold"},
                  {rsp_valid, rsp_timeout, rsp_resp, cmd_ready, m_axi_awvalid, m_axi_arvalid,
                   rsp_rdata[24:0]},
                  {1'b1, v.exp_to, v.exp_resp, 1'b0, 1'b0, 1'b0, v.exp_rdata[24:0]});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk_i);
        rsp_ready = 1'b0;
        check({tag, ".released"}, {30'd0, rsp_valid, cmd_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got stuck expected done");
        $fatal(1);
    end

    initial begin
        //           wr    addr           wdata          strb  aw     w  b      ar     r      sresp  srdata        hold lat eresp  erdata         to    hs
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0,     0, 0,     0,     0,     2'b00, 32'h0,        0,   3,  2'b00, 32'h0,         1'b0, 5'b11100};
        vecs[1]  = '{1'b1, 32'h0000_0020, 32'hCAFE_BABE, 4'hF, 0,     3, 0,     0,     0,     2'b00, 32'h0,        0,   6,  2'b00, 32'h0,         1'b0, 5'b11100};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 0,     0, 0,     5,     0,     2'b00, 32'h1234_5678, 0,  8,  2'b00, 32'h1234_5678, 1'b0, 5'b00011};
        vecs[3]  = '{1'b1, 32'h0000_0030, 32'h1122_3344, 4'h5, 2,     0, 0,     0,     0,     2'b10, 32'h0,        0,   5,  2'b10, 32'h0,         1'b0, 5'b11100};
        vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0,     0, 0,     0,     3,     2'b11, 32'hCAFE_F00D, 4,  6,  2'b11, 32'hCAFE_F00D, 1'b0, 5'b00011};
        vecs[5]  = '{1'b1, 32'h0000_0040, 32'h0000_00A5, 4'h8, 0,     0, 2,     0,     0,     2'b00, 32'h0,        4,   5,  2'b00, 32'h0,         1'b0, 5'b11100};
        vecs[6]  = '{1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'hF, 0,     0, NEVER, 0,     0,     2'b00, 32'h0,        0,   17, 2'b10, 32'h0,         1'b1, 5'b11000};
        vecs[7]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 0,     0, 0,     0,     0,     2'b00, 32'h0BAD_CAFE, 0,  3,  2'b00, 32'h0BAD_CAFE, 1'b0, 5'b00011};
        vecs[8]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0,     0, 0,     NEVER, 0,     2'b00, 32'h7777_7777, 0,  17, 2'b10, 32'h0,         1'b1, 5'b00000};
        vecs[9]  = '{1'b0, 32'h0000_0018, 32'h0,         4'h0, 0,     0, 0,     0,     NEVER, 2'b00, 32'h7777_7777, 2,  17, 2'b10, 32'h0,         1'b1, 5'b00010};
        vecs[10] = '{1'b1, 32'h0000_001C, 32'h0F0F_0F0F, 4'hC, NEVER, 0, 0,     0,     0,     2'b00, 32'h0,        0,   17, 2'b10, 32'h0,         1'b1, 5'b01000};
        final_vec = '{1'b1, 32'h0000_0060, 32'h8765_4321, 4'hF, 0,    0, 0,     0,     0,     2'b01, 32'h0,        0,   3,  2'b01, 32'h0,         1'b0, 5'b11100};

        rst_ni    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        slave_idle();
        repeat (2) @(negedge clk_i);
        check("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset.chan", chan_bits(), 32'd0);
        check("reset.rsp", {28'd0, rsp_valid, rsp_timeout, rsp_resp}, 32'd0);
        check("reset.rdata", rsp_rdata, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_reset.cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

        // Reset pulse while the write address/data are still waiting for ready.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0070;
        cmd_wdata = 32'hAAAA_5555;
        cmd_wstrb = 4'hF;
        @(negedge clk_i);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        check("midrst.in_wr_req", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst.chan", chan_bits(), 32'd0);
        check("midrst.cmd_ready", {30'd0, cmd_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("midrst.quiet", {29'd0, cmd_ready, rsp_valid, |chan_bits()}, {29'd0, 1'b1, 1'b0, 1'b0});
        end

        run_txn(final_vec, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
